// File: rtl/la_sram_sequencer.sv
// -----------------------------------------------------------------------------
// la_sram_sequencer
//
// Sequences a pair (LA_CHIPS) of quad-SPI SRAMs used as logic-analyzer sample
// memory. Capture mode sends WRITE 0x02 + address 0x000000, then writes one LA
// sample per sample_en strobe. Each chip stores one nibble of every sample.
// Readback mode sends READ 0x03 + address 0x000000 and one dummy byte, then
// clocks out one sample per rd_next pulse.
//
// Every SQI nibble takes two clk cycles: phase L (sram_clock=0, data set up)
// and phase H (sram_clock=1). The SRAM samples on the rising sram_clock edge.
//
// Optional feature: define LA_TRIGGER_EN to add trig_mask/trig_value and an
// ARM state. In ARM, capture waits for the first strobe whose masked sample
// equals the masked trigger value. That strobe becomes sample 0.
//
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   start, rd_start  begin capture / readback (ignored while busy)
//   rd_next          fetch the next readback sample
//   abort            return to IDLE from any state, chips deselected
//   sample_count     samples to capture (latched on start)
//   la_sample        latched LA pin data
//   sample_en        sample-rate strobe
//   lat_oe           LA input latch enable (capture states)
//   sram_clock       SQI clock, one identical bit per chip
//   sram_cs          active-low chip selects, one identical bit per chip
//   sram_sio_o       sio drive data, nibble k to chip k
//   sram_sio_oe      1 = this block drives sio
//   sram_sio_i       sio read data
//   rd_data          last read sample
//   rd_valid         one-cycle pulse when rd_data updates
//   busy             state is not IDLE
//   done             one-cycle pulse at capture completion
//   overrun          sticky, a strobe arrived during a transfer (cleared on start)
//   captured         samples written in the current/last capture
// -----------------------------------------------------------------------------
module la_sram_sequencer #(
    parameter int LA_WIDTH    = 8,
    parameter int LA_CHIPS    = 2,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   rd_start,
    input  logic                   rd_next,
    input  logic                   abort,
    input  logic [COUNT_WIDTH-1:0] sample_count,
    input  logic [LA_WIDTH-1:0]    la_sample,
    input  logic                   sample_en,
`ifdef LA_TRIGGER_EN
    input  logic [LA_WIDTH-1:0]    trig_mask,
    input  logic [LA_WIDTH-1:0]    trig_value,
`endif
    output logic                   lat_oe,
    output logic [LA_CHIPS-1:0]    sram_clock,
    output logic [LA_CHIPS-1:0]    sram_cs,
    output logic [LA_WIDTH-1:0]    sram_sio_o,
    output logic                   sram_sio_oe,
    input  logic [LA_WIDTH-1:0]    sram_sio_i,
    output logic [LA_WIDTH-1:0]    rd_data,
    output logic                   rd_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun,
    output logic [COUNT_WIDTH-1:0] captured
);

    typedef enum logic [3:0] {
        S_IDLE, S_WCMD, S_CAPT, S_WDONE, S_RCMD, S_RDUMMY, S_RWAIT, S_RCLK
`ifdef LA_TRIGGER_EN
        , S_ARM
`endif
    } state_t;

    state_t                 state_reg, state_next;
    logic                   phase_reg, phase_next;       // 0 = phase L, 1 = phase H
    logic                   xfer_reg, xfer_next;         // CAPT: sample transfer in flight
    logic [2:0]             nib_cnt_reg, nib_cnt_next;
    logic [COUNT_WIDTH-1:0] count_reg, count_next;
    logic [COUNT_WIDTH-1:0] captured_reg, captured_next;
    logic                   overrun_reg, overrun_next;
    logic [LA_WIDTH-1:0]    sample_reg, sample_next;
    logic [LA_WIDTH-1:0]    rd_data_reg, rd_data_next;
    logic                   rd_valid_reg, rd_valid_next;

    logic                   cs_n, sclk, cmd_sel, data_sel;
    logic [3:0]             cmd_nib;
    logic [COUNT_WIDTH-1:0] captured_inc;

    assign captured_inc = captured_reg + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= S_IDLE;
            phase_reg    <= 1'b0;
            xfer_reg     <= 1'b0;
            nib_cnt_reg  <= '0;
            count_reg    <= '0;
            captured_reg <= '0;
            overrun_reg  <= 1'b0;
            sample_reg   <= '0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            phase_reg    <= phase_next;
            xfer_reg     <= xfer_next;
            nib_cnt_reg  <= nib_cnt_next;
            count_reg    <= count_next;
            captured_reg <= captured_next;
            overrun_reg  <= overrun_next;
            sample_reg   <= sample_next;
            rd_data_reg  <= rd_data_next;
            rd_valid_reg <= rd_valid_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        phase_next    = phase_reg;
        xfer_next     = xfer_reg;
        nib_cnt_next  = nib_cnt_reg;
        count_next    = count_reg;
        captured_next = captured_reg;
        overrun_next  = overrun_reg;
        sample_next   = sample_reg;
        rd_data_next  = rd_data_reg;
        rd_valid_next = 1'b0;
        cs_n          = 1'b1;
        sclk          = 1'b0;
        sram_sio_oe   = 1'b0;
        lat_oe        = 1'b0;
        done          = 1'b0;
        cmd_sel       = 1'b0;
        data_sel      = 1'b0;
        cmd_nib       = 4'h0;

        // Next state. abort beats everything, including start.
        if (abort) begin
            state_next   = S_IDLE;
            phase_next   = 1'b0;
            xfer_next    = 1'b0;
            nib_cnt_next = '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    phase_next   = 1'b0;
                    nib_cnt_next = '0;
                    if (start) begin
                        count_next    = sample_count;
                        captured_next = '0;
                        overrun_next  = 1'b0;
                        // Zero-length capture never selects the chips.
                        state_next    = (sample_count == '0) ? S_WDONE : S_WCMD;
                    end else if (rd_start) begin
                        state_next = S_RCMD;
                    end
                end
                S_WCMD, S_RCMD: begin
                    phase_next = ~phase_reg;
                    if (phase_reg) begin
                        nib_cnt_next = nib_cnt_reg + 3'd1;   // wraps to 0 after nibble 7
                        if (nib_cnt_reg == 3'd7) begin
                            if (state_reg == S_RCMD) begin
                                state_next = S_RDUMMY;
                            end else begin
`ifdef LA_TRIGGER_EN
                                state_next = S_ARM;
`else
                                state_next = S_CAPT;
`endif
                            end
                        end
                    end
                end
`ifdef LA_TRIGGER_EN
                S_ARM: begin
                    // The triggering strobe is written as sample 0.
                    if (sample_en && ((la_sample & trig_mask) == (trig_value & trig_mask))) begin
                        state_next  = S_CAPT;
                        sample_next = la_sample;
                        xfer_next   = 1'b1;
                        phase_next  = 1'b0;
                    end
                end
`endif
                S_CAPT: begin
                    if (xfer_reg) begin
                        // A strobe while a sample is still on the bus is lost.
                        if (sample_en) overrun_next = 1'b1;
                        phase_next = ~phase_reg;
                        if (phase_reg) begin
                            xfer_next     = 1'b0;
                            captured_next = captured_inc;
                            if (captured_inc == count_reg) state_next = S_WDONE;
                        end
                    end else if (sample_en) begin
                        sample_next = la_sample;
                        xfer_next   = 1'b1;
                        phase_next  = 1'b0;
                    end
                end
                S_WDONE: state_next = S_IDLE;
                S_RDUMMY: begin
                    phase_next = ~phase_reg;
                    if (phase_reg) begin
                        nib_cnt_next = nib_cnt_reg + 3'd1;
                        if (nib_cnt_reg == 3'd1) begin
                            nib_cnt_next = '0;
                            state_next   = S_RWAIT;
                        end
                    end
                end
                S_RWAIT: begin
                    if (rd_next) begin
                        state_next = S_RCLK;
                        phase_next = 1'b0;
                    end
                end
                S_RCLK: begin
                    phase_next = ~phase_reg;
                    if (phase_reg) begin
                        rd_data_next  = sram_sio_i;
                        rd_valid_next = 1'b1;
                        state_next    = S_RWAIT;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end

        // Pin-side outputs are decoded from the current state only.
        case (state_reg)
            S_WCMD: begin
                cs_n        = 1'b0;
                sram_sio_oe = 1'b1;
                sclk        = phase_reg;
                cmd_sel     = 1'b1;
                cmd_nib     = (nib_cnt_reg == 3'd1) ? 4'h2 : 4'h0;
            end
            S_RCMD: begin
                cs_n        = 1'b0;
                sram_sio_oe = 1'b1;
                sclk        = phase_reg;
                cmd_sel     = 1'b1;
                cmd_nib     = (nib_cnt_reg == 3'd1) ? 4'h3 : 4'h0;
            end
`ifdef LA_TRIGGER_EN
            S_ARM: begin
                cs_n        = 1'b0;
                sram_sio_oe = 1'b1;
                lat_oe      = 1'b1;
            end
`endif
            S_CAPT: begin
                cs_n        = 1'b0;
                sram_sio_oe = 1'b1;
                lat_oe      = 1'b1;
                sclk        = xfer_reg & phase_reg;
                data_sel    = 1'b1;
            end
            S_WDONE: done = 1'b1;
            S_RDUMMY, S_RCLK: begin
                cs_n = 1'b0;
                sclk = phase_reg;
            end
            S_RWAIT: cs_n = 1'b0;
            default: ;
        endcase
    end

    // Commands go to every chip; sample data is split one nibble per chip.
    for (genvar gi = 0; gi < LA_CHIPS; gi++) begin : g_chip
        assign sram_sio_o[4*gi +: 4] = cmd_sel  ? cmd_nib :
                                       data_sel ? sample_reg[4*gi +: 4] : 4'h0;
        assign sram_clock[gi]        = sclk;
        assign sram_cs[gi]           = cs_n;
    end

    assign busy     = (state_reg != S_IDLE);
    assign overrun  = overrun_reg;
    assign captured = captured_reg;
    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;

endmodule

// File: tb/tb_la_sram_sequencer.sv
// -----------------------------------------------------------------------------
// tb_la_sram_sequencer
//
// Self-checking bench for la_sram_sequencer. A pin monitor records every rising
// sram_clock edge while the chips are selected ({oe, sio_o}). Each capture is
// compared against a reference built from the strobe timeline. Acceptance rule:
// a strobe is dropped, and overrun is set, when it comes within two cycles of
// the last accepted strobe. Before the trigger matches, strobes are simply
// ignored. Readback data comes from the bench-driven sram_sio_i values.
// -----------------------------------------------------------------------------
module tb_la_sram_sequencer;

    localparam int LW = 8;
    localparam int LC = 2;
    localparam int CW = 16;
`ifdef LA_TRIGGER_EN
    localparam bit TRIG = 1'b1;
`else
    localparam bit TRIG = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0, rd_start = 1'b0, rd_next = 1'b0, abort = 1'b0;
    logic [CW-1:0] sample_count = '0;
    logic [LW-1:0] la_sample = '0;
    logic          sample_en = 1'b0;
    logic [LW-1:0] trig_mask = '0, trig_value = '0;
    logic [LW-1:0] sram_sio_i = '0;
    logic          lat_oe, sram_sio_oe, rd_valid, busy, done, overrun;
    logic [LC-1:0] sram_clock, sram_cs;
    logic [LW-1:0] sram_sio_o, rd_data;
    logic [CW-1:0] captured;

    int pass_cnt = 0, total_cnt = 0, fail_cnt = 0;
    logic [8:0] mon_q[$];
    int  done_cnt = 0, rv_cnt = 0;
    bit  cs_low_seen = 1'b0, split_err = 1'b0, prev_sclk = 1'b0;
    logic [7:0] stim_s[$];
    int  stim_g[$];

    la_sram_sequencer #(.LA_WIDTH(LW), .LA_CHIPS(LC), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .rd_start(rd_start), .rd_next(rd_next),
        .abort(abort), .sample_count(sample_count), .la_sample(la_sample),
        .sample_en(sample_en),
`ifdef LA_TRIGGER_EN
        .trig_mask(trig_mask), .trig_value(trig_value),
`endif
        .lat_oe(lat_oe), .sram_clock(sram_clock), .sram_cs(sram_cs),
        .sram_sio_o(sram_sio_o), .sram_sio_oe(sram_sio_oe), .sram_sio_i(sram_sio_i),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
        .overrun(overrun), .captured(captured)
    );

    always #5 clk = ~clk;

    // Pin monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!sram_cs[0] && sram_clock[0] && !prev_sclk) mon_q.push_back({sram_sio_oe, sram_sio_o});
        prev_sclk = sram_clock[0];
        if (done) done_cnt++;
        if (rd_valid) rv_cnt++;
        if (!sram_cs[0]) cs_low_seen = 1'b1;
        if (sram_cs[1] != sram_cs[0] || sram_clock[1] != sram_clock[0]) split_err = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        assert (got === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic gen_stim(input int n);
        stim_s.delete();
        stim_g.delete();
        for (int i = 0; i < n; i++) begin
            stim_s.push_back(8'($urandom_range(255)));
            // Even-indexed gaps are at least 3 cycles, so at least half the strobes land.
            stim_g.push_back((i % 2 == 1) ? int'($urandom_range(1, 4)) : int'($urandom_range(3, 6)));
        end
    endtask

    task automatic run_capture(input int cnt, input bit also_rd);
        logic [7:0] exp_q[$];
        logic [8:0] e;
        int acc = 0, last_acc = -100, t = 0, waited = 0;
        bit exp_ovr = 1'b0, hit = !TRIG;
        mon_q.delete();
        done_cnt = 0;
        sample_count = 16'(cnt);
        start = 1'b1;
        rd_start = also_rd;
        tick();
        start = 1'b0;
        rd_start = 1'b0;
        while (!lat_oe && waited < 40) begin tick(); waited++; end
        check("lat_oe_rise", 32'(lat_oe), 32'd1);
        for (int i = 0; i < stim_s.size() && acc < cnt; i++) begin
            if (t - last_acc <= 2) begin
                exp_ovr = 1'b1;
            end else if (hit || ((stim_s[i] & trig_mask) == (trig_value & trig_mask))) begin
                hit = 1'b1;
                exp_q.push_back(stim_s[i]);
                acc++;
                last_acc = t;
            end
            la_sample = stim_s[i];
            sample_en = 1'b1;
            tick();
            sample_en = 1'b0;
            for (int j = 1; j < stim_g[i]; j++) tick();
            t += stim_g[i];
        end
        waited = 0;
        while (done_cnt == 0 && waited < 30) begin tick(); waited++; end
        tick();
        check("done_timeout", 32'(waited < 30), 32'd1);
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("captured", 32'(captured), 32'(cnt));
        check("overrun", 32'(overrun), 32'(exp_ovr));
        check("busy_after", 32'(busy), 32'd0);
        check("cs_after", 32'(sram_cs), 32'h3);
        check("stream_len", 32'(mon_q.size()), 32'(8 + exp_q.size()));
        for (int k = 0; k < 8 && k < mon_q.size(); k++) begin
            e = {1'b1, (k == 1) ? 8'h22 : 8'h00};
            check("wcmd_nibble", 32'(mon_q[k]), 32'(e));
        end
        for (int k = 0; k < exp_q.size() && 8 + k < mon_q.size(); k++) begin
            e = {1'b1, exp_q[k]};
            check("write_sample", 32'(mon_q[8 + k]), 32'(e));
        end
        $display("capture count=%0d accepted=%0d overrun=%0b captured=%0d", cnt, exp_q.size(), exp_ovr, captured);
    endtask

    task automatic run_readback(input int nreads);
        logic [7:0] d;
        logic [8:0] e;
        int waited = 0;
        mon_q.delete();
        rv_cnt = 0;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        while (mon_q.size() < 10 && waited < 40) begin tick(); waited++; end
        tick();
        check("rd_preamble_len", 32'(mon_q.size()), 32'd10);
        for (int k = 0; k < 8 && k < mon_q.size(); k++) begin
            e = {1'b1, (k == 1) ? 8'h33 : 8'h00};
            check("rcmd_nibble", 32'(mon_q[k]), 32'(e));
        end
        for (int k = 8; k < 10 && k < mon_q.size(); k++) check("dummy_oe", 32'(mon_q[k][8]), 32'd0);
        for (int r = 0; r < nreads; r++) begin
            d = (r == 0) ? 8'hAA : (r == 1) ? 8'h55 : 8'($urandom_range(255));
            sram_sio_i = d;
            rd_next = 1'b1;
            tick();
            rd_next = (r == 2);      // second pulse during the transfer must be ignored
            check("rd_valid_early1", 32'(rd_valid), 32'd0);
            tick();
            rd_next = 1'b0;
            check("rd_valid_early2", 32'(rd_valid), 32'd0);
            tick();
            check("rd_valid", 32'(rd_valid), 32'd1);
            check("rd_data", 32'(rd_data), 32'(d));
            tick();
            check("rd_valid_drop", 32'(rd_valid), 32'd0);
            $display("readback %0d data=0x%02h rd_data=0x%02h", r, d, rd_data);
        end
        check("rd_valid_pulses", 32'(rv_cnt), 32'(nreads));
        check("rd_clock_count", 32'(mon_q.size()), 32'(10 + nreads));
        for (int k = 10; k < mon_q.size(); k++) check("rclk_oe", 32'(mon_q[k][8]), 32'd0);
        check("rd_cs_low", 32'(sram_cs), 32'h0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("rd_abort_cs", 32'(sram_cs), 32'h3);
        check("rd_abort_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        // Reset values.
        repeat (3) tick();
        check("rst_cs", 32'(sram_cs), 32'h3);
        check("rst_clock", 32'(sram_clock), 32'h0);
        check("rst_oe", 32'(sram_sio_oe), 32'd0);
        check("rst_sio_o", 32'(sram_sio_o), 32'h0);
        check("rst_lat_oe", 32'(lat_oe), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'h0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_captured", 32'(captured), 32'h0);
        rst = 1'b1;
        tick();

        // Directed capture of four samples, 4-cycle strobe spacing.
        stim_s = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        stim_g = '{4, 4, 4, 4};
        run_capture(4, 1'b0);

        // Strobes while idle after completion change nothing.
        la_sample = 8'h77;
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        tick();
        check("idle_strobe_captured", 32'(captured), 32'd4);
        check("idle_strobe_cs", 32'(sram_cs), 32'h3);

        // Back-to-back strobes: the second one is dropped.
        stim_s = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        stim_g = '{1, 4, 4, 4, 4};
        run_capture(3, 1'b0);
        check("overrun_directed", 32'(overrun), 32'd1);

        // Randomized captures.
        for (int n = 0; n < 4; n++) begin
            int c;
            c = int'($urandom_range(1, 6));
            gen_stim(2 * c + 2);
            run_capture(c, 1'b0);
        end

        // start and rd_start together: capture wins.
        gen_stim(6);
        run_capture(2, 1'b1);

        // Zero-length capture.
        cs_low_seen = 1'b0;
        done_cnt = 0;
        sample_count = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("zero_done", 32'(done), 32'd1);
        check("zero_busy", 32'(busy), 32'd1);
        tick();
        check("zero_done_drop", 32'(done), 32'd0);
        check("zero_done_count", 32'(done_cnt), 32'd1);
        check("zero_cs_never_low", 32'(cs_low_seen), 32'd0);
        check("zero_captured", 32'(captured), 32'd0);

        // Abort during the 5th WCMD nibble.
        mon_q.delete();
        done_cnt = 0;
        sample_count = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_cs", 32'(sram_cs), 32'h3);
        check("abort_clock", 32'(sram_clock), 32'h0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_oe", 32'(sram_sio_oe), 32'd0);
        check("abort_nibbles_sent", 32'(mon_q.size()), 32'd4);
        tick();
        check("abort_no_done", 32'(done_cnt), 32'd0);
        gen_stim(8);
        run_capture(3, 1'b0);

        // Abort mid-capture keeps the captured count.
        done_cnt = 0;
        sample_count = 16'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int w = 0; w < 40 && !lat_oe; w++) tick();
        for (int s = 0; s < 2; s++) begin
            la_sample = 8'(s + 8'h60);
            sample_en = 1'b1;
            tick();
            sample_en = 1'b0;
            repeat (3) tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_capt_captured", 32'(captured), 32'd2);
        check("abort_capt_busy", 32'(busy), 32'd0);
        check("abort_capt_lat_oe", 32'(lat_oe), 32'd0);
        tick();
        check("abort_capt_no_done", 32'(done_cnt), 32'd0);
        check("abort_capt_hold", 32'(captured), 32'd2);

        // Readback.
        run_readback(5);

        // Asynchronous reset in the middle of a transfer.
        sample_count = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int w = 0; w < 40 && !lat_oe; w++) tick();
        la_sample = 8'h5A;
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        tick();
        check("pre_reset_clock_high", 32'(sram_clock), 32'h3);
        #2 rst = 1'b0;
        #1;
        check("areset_cs", 32'(sram_cs), 32'h3);
        check("areset_clock", 32'(sram_clock), 32'h0);
        check("areset_busy", 32'(busy), 32'd0);
        check("areset_lat_oe", 32'(lat_oe), 32'd0);
        check("areset_captured", 32'(captured), 32'h0);
        #1 rst = 1'b1;
        tick();
        check("areset_idle", 32'(busy), 32'd0);

`ifdef LA_TRIGGER_EN
        // Trigger: only samples whose low nibble is 5 start the capture.
        trig_mask = 8'h0F;
        trig_value = 8'h05;
        stim_s = '{8'h10, 8'h23, 8'h35, 8'h46};
        stim_g = '{4, 4, 4, 4};
        run_capture(2, 1'b0);
        if (mon_q.size() >= 10) begin
            check("trig_sample0", 32'(mon_q[8][7:0]), 32'h35);
            check("trig_sample1", 32'(mon_q[9][7:0]), 32'h46);
        end else begin
            check("trig_stream_len", 32'(mon_q.size()), 32'd10);
        end
        trig_mask = '0;
        trig_value = '0;
`endif

        gen_stim(10);
        run_capture(4, 1'b0);

        check("cs_clk_bits_equal", 32'(split_err), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
